fft_out_streamer: RTL
=====================

# fft_out_streamer

Output-side companion to `fft_top`. It captures one frame of 16 parallel complex FFT bins, Q16.16 signed, in a single handshake, then emits the bins one per cycle, in index order, on a valid/ready stream. This converts the FFT's wide parallel result bus into a narrow stream for downstream logic or DMA. The block sits directly after `fft_top`; its capture port connects to the `fft_outK_real`/`fft_outK_imag` buses.

## Interface
Parameters:
- `N`, 16, bins per frame; power of two, 2..64.
- `W`, 32, bits per real/imag component (Q16.16 two's complement).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  a complete frame is present on `in_real`/`in_imag`.
- `in_ready`  out  1  block can capture a frame this cycle.
- `in_real`  in  N*W  bin k real part at bits [k*W +: W].
- `in_imag`  in  N*W  bin k imaginary part at bits [k*W +: W].
- `out_valid`  out  1  `out_real`/`out_imag` hold a valid bin.
- `out_ready`  in  1  downstream accepts the current bin.
- `out_real`  out  W  current bin real part.
- `out_imag`  out  W  current bin imaginary part.
- `out_index`  out  log2(N)  index of the current bin.
- `out_last`  out  1  current bin is bin N-1.
- `frame_cnt`  out  16  count of completed frames; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture all N bins into the internal buffer, set idx=0, go to STREAM.
- STREAM:
  - `out_valid`=1; outputs are buffer[idx]; `out_index`=idx; `out_last`=(idx==N-1).
  - Beat accepted when `out_valid && out_ready`; on acceptance idx increments.
  - Accepting the last beat increments `frame_cnt`. Then:
    - if `in_valid` is high in that same cycle, capture the new frame, set idx=0 and stay in STREAM (back-to-back frames, no bubble);
    - otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (`out_valid && out_ready && out_last`). It is combinational from state and `out_ready`.
- While `out_valid && !out_ready`, all output fields hold stable.
- `in_valid` while `in_ready`=0 is ignored; the buffer is not modified.
- Arithmetic: no modification unless the scaling feature below is enabled.

## Timing
- Reset values: state=IDLE, idx=0, `out_valid`=0, `out_real`=0, `out_imag`=0, `out_index`=0, `out_last`=0, `frame_cnt`=0. `in_ready`=1 once `rst` is high.
- Latency: capture at edge T; bin 0 is valid after edge T; with `out_ready` held high, bin k is accepted at edge T+1+k.
- Throughput: N cycles per frame with continuous `out_ready` and back-to-back `in_valid`.
- Reset asserted mid-frame: the frame is aborted immediately, outputs go to reset values and the partial frame is never resumed. `frame_cnt` is not incremented for the aborted frame.
- Stalls: there is no timeout; the block holds indefinitely.

## Configuration
- Macro `FFT_STREAM_SCALE_EN`.
- Defined: each component is arithmetically shifted right by log2(N) at capture, giving 1/N normalization with truncation toward −∞.
  - 0x00100000 (16.0) → 0x00010000.
  - 0xFFFF0000 (−1.0) → 0xFFFFF000.
- Undefined: components pass unchanged. Latency and handshake are identical in both builds.

## Test plan
- Reset/idle: hold `rst`=0 for 10 cycles, then release → all outputs 0, `in_ready`=1, `out_valid`=0.
- Single frame, sink always ready: FFT of real ramp 1..8 followed by 8 zeros.
  - bin0 real = 0x00240000 (36.0), imag = 0 → emitted first with `out_index`=0.
  - 16 beats on consecutive cycles; `out_last` only on beat 15; `frame_cnt`=1.
- Backpressure: drop `out_ready` for 5 cycles at idx=7 → bin 7 fields and `out_index`=7 stable throughout; no beat lost or duplicated; `in_valid` asserted during the stall is ignored.
- Back-to-back: `in_valid` held high for 3 frames with distinct patterns → 48 beats with no gap; `in_ready` pulses only on last beats; `frame_cnt`=3.
- Mid-frame reset: assert `rst`=0 at idx=9 → `out_valid`=0 asynchronously; after release `frame_cnt`=0; the next frame starts at bin 0.
- Scaling build with `FFT_STREAM_SCALE_EN`: input bin real 0x00100000 and imag 0xFFFF0000 → output 0x00010000 and 0xFFFFF000. Without the macro, the same frame outputs unchanged values.

Source files
------------

// File: rtl/fft_out_streamer_if.sv
// rtl/fft_out_streamer_if.sv - frame capture and bin stream signals for fft_out_streamer
interface fft_out_streamer_if #(
  parameter int N = 16,
  parameter int W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*W-1:0]         in_real;
  logic [N*W-1:0]         in_imag;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_real;
  logic [W-1:0]           out_imag;
  logic [$clog2(N)-1:0]   out_index;
  logic                   out_last;

  // master: the environment around the streamer (frame source and bin sink)
  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last
  );

  // slave: the streamer itself
  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last
  );
endinterface

// File: rtl/fft_out_streamer.sv
// rtl/fft_out_streamer.sv - captures N parallel complex FFT bins and streams them one per cycle
// Optional 1/N normalization at capture when FFT_STREAM_SCALE_EN is defined.
module fft_out_streamer #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  fft_out_streamer_if.slave s,
  output logic [15:0]       frame_cnt
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [W-1:0]  buf_real [N];
  logic [W-1:0]  buf_imag [N];
  logic [W-1:0]  cap_real [N];
  logic [W-1:0]  cap_imag [N];
  logic          accept;
  logic          last_accept;
  logic          capture;

  always_comb begin
    for (int k = 0; k < N; k++) begin
`ifdef FFT_STREAM_SCALE_EN
      cap_real[k] = $signed(s.in_real[k*W +: W]) >>> IW;
      cap_imag[k] = $signed(s.in_imag[k*W +: W]) >>> IW;
`else
      cap_real[k] = s.in_real[k*W +: W];
      cap_imag[k] = s.in_imag[k*W +: W];
`endif
    end
  end

  assign accept      = s.out_valid && s.out_ready;
  assign last_accept = accept && s.out_last;
  // Ready on the final accepted beat lets the next frame load with no bubble.
  assign s.in_ready  = (state == IDLE) || last_accept;
  assign capture     = s.in_valid && s.in_ready;
  assign idx_nxt     = idx + 1'b1;
  assign s.out_index = idx;

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        buf_real[k] <= cap_real[k];
        buf_imag[k] <= cap_imag[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      s.out_valid <= 1'b0;
      s.out_real  <= '0;
      s.out_imag  <= '0;
      s.out_last  <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      if (last_accept) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // Bin 0 is taken straight from the capture bus; the buffer is written on the same edge.
      if (capture) begin
        state       <= STREAM;
        idx         <= '0;
        s.out_valid <= 1'b1;
        s.out_real  <= cap_real[0];
        s.out_imag  <= cap_imag[0];
        s.out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            s.out_valid <= 1'b0;
          end
          STREAM: begin
            if (last_accept) begin
              state       <= IDLE;
              idx         <= '0;
              s.out_valid <= 1'b0;
              s.out_real  <= '0;
              s.out_imag  <= '0;
              s.out_last  <= 1'b0;
            end else if (accept) begin
              idx        <= idx_nxt;
              s.out_real <= buf_real[idx_nxt];
              s.out_imag <= buf_imag[idx_nxt];
              s.out_last <= (idx_nxt == IW'(N - 1));
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
